// File: rtl/axi_rom_slave_pkg.sv
// Shared AXI read-side constants and helpers for the instruction ROM responder and its address generator.
// Pure definitions: no state, no latency, no flow control.
package axi_rom_slave_pkg;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    function automatic logic [2:0] clamp_size(input logic [2:0] size, input logic [2:0] max_size);
        return (size > max_size) ? max_size : size;
    endfunction

    // Only these lengths form a legal wrap container; anything else degrades to INCR.
    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational next-beat address for FIXED/INCR/WRAP bursts; shared with the icache and DMA.
// Zero latency, no flow control; reserved burst encoding 11 steps like INCR.
module axi_burst_addr_gen
    import axi_rom_slave_pkg::*;
(
    input  logic [31:0] addr,
    input  logic [2:0]  size,
    input  logic [7:0]  len,
    input  logic [1:0]  burst,
    output logic [31:0] next_addr
);

    logic [31:0] step;
    logic [31:0] incr_addr;
    logic [31:0] wrap_mask;
    logic [31:0] wrap_addr;

    always_comb begin
        step      = 32'd1 << size;
        incr_addr = addr + step;
        wrap_mask = ((32'(len) + 32'd1) << size) - 32'd1;
        wrap_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
        next_addr = incr_addr;
        if (burst == AXI_BURST_FIXED) begin
            next_addr = addr;
        end else if ((burst == AXI_BURST_WRAP) && wrap_len_ok(len)) begin
            next_addr = wrap_addr;
        end
    end

endmodule

// File: rtl/axi_rom_slave.sv
// AXI4 read-only ROM responder, one outstanding burst; first beat RD_LATENCY+1 cycles after AR handshake.
// R fields are registered and held while rvalid && !rready; AR is only accepted in IDLE.
module axi_rom_slave
    import axi_rom_slave_pkg::*;
#(
    parameter int    DATA_WIDTH  = 32,
    parameter int    DEPTH_WORDS = 1024,
    parameter int    RD_LATENCY  = 1,
    parameter string INIT_FILE   = ""
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    output logic                  arready,
    input  logic                  arvalid,
    input  logic [31:0]           araddr,
    input  logic [3:0]            arid,
    input  logic [7:0]            arlen,
    input  logic [2:0]            arsize,
    input  logic [1:0]            arburst,
    input  logic                  rready,
    output logic                  rvalid,
    output logic [1:0]            rresp,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rlast,
    output logic [3:0]            rid
);

    localparam int          MAX_SIZE  = $clog2(DATA_WIDTH / 8);
    localparam int          IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [32:0] ROM_BYTES = 33'(DEPTH_WORDS * (DATA_WIDTH / 8));

    typedef enum logic [1:0] {idle_t, wait_t, beat_t} state_e;

    // Image storage; contents survive reset and are loaded from outside the control path.
    logic [DATA_WIDTH-1:0] rom_mem [DEPTH_WORDS];

    state_e                state_q, state_d;
    logic                  arready_q, arready_d;
    logic                  rvalid_q, rvalid_d;
    logic                  rlast_q, rlast_d;
    logic [3:0]            rid_q, rid_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [31:0]           addr_q, addr_d;
    logic [7:0]            len_q, len_d;
    logic [2:0]            size_q, size_d;
    logic [1:0]            burst_q, burst_d;
    logic [7:0]            idx_q, idx_d;
    logic [3:0]            wait_q, wait_d;

    // The beat being loaded comes straight from AR when latency is zero, else from the latched burst.
    logic                  is_idle;
    logic [31:0]           pres_addr;
    logic [2:0]            pres_size;
    logic [7:0]            pres_len;
    logic [1:0]            pres_burst;
    logic [7:0]            pres_idx;
    logic                  in_range;
    logic [31:0]           next_addr;
    logic                  load_beat;

    assign is_idle    = (state_q == idle_t);
    assign pres_addr  = is_idle ? araddr : addr_q;
    assign pres_size  = is_idle ? clamp_size(arsize, 3'(MAX_SIZE)) : size_q;
    assign pres_len   = is_idle ? arlen : len_q;
    assign pres_burst = is_idle ? arburst : burst_q;
    assign pres_idx   = is_idle ? 8'd0 : idx_q;
    assign in_range   = ({1'b0, pres_addr} < ROM_BYTES);

    axi_burst_addr_gen u_addr_gen (
        .addr      (pres_addr),
        .size      (pres_size),
        .len       (pres_len),
        .burst     (pres_burst),
        .next_addr (next_addr)
    );

    always_comb begin
        state_d   = state_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        rid_d     = rid_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        addr_d    = addr_q;
        len_d     = len_q;
        size_d    = size_q;
        burst_d   = burst_q;
        idx_d     = idx_q;
        wait_d    = wait_q;
        load_beat = 1'b0;

        case (state_q)
            idle_t: begin
                arready_d = 1'b1;
                if (arvalid && arready_q) begin
                    arready_d = 1'b0;
                    rid_d     = arid;
                    addr_d    = araddr;
                    len_d     = arlen;
                    size_d    = pres_size;
                    burst_d   = arburst;
                    idx_d     = 8'd0;
                    wait_d    = 4'(RD_LATENCY);
                    if (RD_LATENCY == 0) begin
                        load_beat = 1'b1;
                        state_d   = beat_t;
                    end else begin
                        state_d   = wait_t;
                    end
                end
            end
            wait_t: begin
                // The beat register loads on the edge the count expires, so rvalid lands on time.
                if (wait_q <= 4'd1) begin
                    load_beat = 1'b1;
                    state_d   = beat_t;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            beat_t: begin
                if (rready) begin
                    if (rlast_q) begin
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                        arready_d = 1'b1;
                        state_d   = idle_t;
                    end else begin
                        load_beat = 1'b1;
                    end
                end
            end
            default: state_d = idle_t;
        endcase

        if (load_beat) begin
            rvalid_d = 1'b1;
            rdata_d  = in_range ? rom_mem[pres_addr[MAX_SIZE +: IDX_W]] : '0;
            rresp_d  = in_range ? AXI_RESP_OKAY : AXI_RESP_DECERR;
            rlast_d  = (pres_idx == pres_len);
            addr_d   = next_addr;
            idx_d    = pres_idx + 8'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= idle_t;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rid_q     <= '0;
            rresp_q   <= '0;
            rdata_q   <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            size_q    <= '0;
            burst_q   <= '0;
            idx_q     <= '0;
            wait_q    <= '0;
        end else begin
            state_q   <= state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rid_q     <= rid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            size_q    <= size_d;
            burst_q   <= burst_d;
            idx_q     <= idx_d;
            wait_q    <= wait_d;
        end
    end

    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rlast   = rlast_q;
    assign rid     = rid_q;
    assign rresp   = rresp_q;
    assign rdata   = rdata_q;

endmodule

// File: tb/tb_axi_rom_slave.sv
// Directed bench for axi_rom_slave: single, INCR, WRAP, FIXED/size clamp, backpressure, range, long burst, reset.
module tb_axi_rom_slave;

    localparam int RD_LATENCY = 1;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        arready, arvalid, rready, rvalid, rlast;
    logic [31:0] araddr, rdata;
    logic [3:0]  arid, rid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst, rresp;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int hs_cyc, first_cyc, hold_viol;
    bit timed_out;

    logic [31:0] cap_data[$];
    logic [1:0]  cap_resp[$];
    logic        cap_last[$];
    logic [3:0]  cap_id[$];
    int          cap_cyc[$];

    axi_rom_slave #(.DATA_WIDTH(32), .DEPTH_WORDS(1024), .RD_LATENCY(RD_LATENCY), .INIT_FILE("")) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .arready(arready), .arvalid(arvalid), .araddr(araddr),
        .arid(arid), .arlen(arlen), .arsize(arsize), .arburst(arburst), .rready(rready),
        .rvalid(rvalid), .rresp(rresp), .rdata(rdata), .rlast(rlast), .rid(rid)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    function automatic logic [31:0] word(input int i);
        return (i == 4) ? 32'hDEADBEEF : (32'hA5A50000 | 32'(i));
    endfunction

    task automatic step();
        @(posedge i_clk); #1;
    endtask

    task automatic issue_ar(input logic [31:0] a, input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input logic [3:0] id);
        int n;
        n = 0;
        while (arready !== 1'b1 && n < 50) begin step(); n++; end
        checks++;
        if (arready !== 1'b1) begin errors++; $display("FAIL ar_ready_wait: arready=%b required 1", arready); end
        arvalid = 1'b1; araddr = a; arlen = len; arsize = size; arburst = burst; arid = id;
        step();
        arvalid = 1'b0;
        hs_cyc = cyc;
    endtask

    task automatic capture(input int stall_beat, input int stalls);
        int idx, stall_left;
        bit have_snap;
        logic [38:0] snap;
        idx = 0; stall_left = stalls; have_snap = 0; hold_viol = 0; timed_out = 1; first_cyc = -1;
        snap = '0;
        cap_data.delete(); cap_resp.delete(); cap_last.delete(); cap_id.delete(); cap_cyc.delete();
        rready = 1'b1;
        for (int c = 0; c < 400; c++) begin
            if (rvalid === 1'b1) begin
                if (first_cyc < 0) first_cyc = cyc;
                if (have_snap && ({rdata, rresp, rlast, rid} !== snap)) hold_viol++;
                if (idx == stall_beat && stall_left > 0) begin
                    if (!have_snap) begin snap = {rdata, rresp, rlast, rid}; have_snap = 1; end
                    rready = 1'b0;
                    stall_left--;
                end else begin
                    rready = 1'b1;
                    cap_data.push_back(rdata); cap_resp.push_back(rresp);
                    cap_last.push_back(rlast); cap_id.push_back(rid); cap_cyc.push_back(cyc);
                    have_snap = 0;
                    idx++;
                    if (rlast === 1'b1) begin step(); timed_out = 0; break; end
                end
            end
            step();
        end
    endtask

    task automatic test_reset();
        step(); step();
        checks++; if (arready !== 1'b0) begin errors++; $display("FAIL reset_arready: got %b want 0", arready); end
        checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b want 0", rvalid); end
        checks++; if (rlast !== 1'b0) begin errors++; $display("FAIL reset_rlast: got %b want 0", rlast); end
        checks++; if (rid !== 4'h0) begin errors++; $display("FAIL reset_rid: got %h want 0", rid); end
        checks++; if (rresp !== 2'b00) begin errors++; $display("FAIL reset_rresp: got %b want 00", rresp); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", rdata); end
        i_rst_n = 1'b1;
        step();
        checks++; if (arready !== 1'b1) begin errors++; $display("FAIL reset_release_arready: got %b want 1", arready); end
    endtask

    task automatic test_single();
        issue_ar(32'h10, 8'd0, 3'd2, 2'b01, 4'd5);
        capture(-1, 0);
        checks++; if (timed_out) begin errors++; $display("FAIL single_timeout: no rlast seen, required one beat"); end
        // Handshake edge to first-beat edge is RD_LATENCY edges, i.e. RD_LATENCY+1 cycles after the AR cycle.
        checks++; if (first_cyc - hs_cyc !== RD_LATENCY) begin errors++; $display("FAIL single_latency: got %0d want %0d", first_cyc - hs_cyc, RD_LATENCY); end
        checks++; if (cap_data.size() !== 1) begin errors++; $display("FAIL single_count: got %0d want 1", cap_data.size()); end
        checks++; if (cap_data[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL single_rdata: got %h want DEADBEEF", cap_data[0]); end
        checks++; if (cap_resp[0] !== 2'b00) begin errors++; $display("FAIL single_rresp: got %b want 00", cap_resp[0]); end
        checks++; if (cap_last[0] !== 1'b1) begin errors++; $display("FAIL single_rlast: got %b want 1", cap_last[0]); end
        checks++; if (cap_id[0] !== 4'd5) begin errors++; $display("FAIL single_rid: got %0d want 5", cap_id[0]); end
    endtask

    task automatic test_incr();
        issue_ar(32'h20, 8'd3, 3'd2, 2'b01, 4'd3);
        capture(-1, 0);
        checks++; if (cap_data.size() !== 4) begin errors++; $display("FAIL incr_count: got %0d want 4", cap_data.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (cap_data[i] !== word(8 + i)) begin errors++; $display("FAIL incr_data%0d: got %h want %h", i, cap_data[i], word(8 + i)); end
            checks++; if (cap_last[i] !== (i == 3)) begin errors++; $display("FAIL incr_last%0d: got %b want %b", i, cap_last[i], i == 3); end
        end
        checks++; if (cap_cyc[3] - cap_cyc[0] !== 3) begin errors++; $display("FAIL incr_spacing: got %0d want 3", cap_cyc[3] - cap_cyc[0]); end
        checks++; if (arready !== 1'b1 || rvalid !== 1'b0) begin errors++; $display("FAIL incr_after: arready=%b rvalid=%b want 1 0", arready, rvalid); end
    endtask

    task automatic test_wrap();
        int exp4[4] = '{10, 11, 8, 9};
        int exp3[3] = '{10, 11, 12};
        issue_ar(32'h28, 8'd3, 3'd2, 2'b10, 4'd7);
        capture(-1, 0);
        checks++; if (cap_data.size() !== 4) begin errors++; $display("FAIL wrap_count: got %0d want 4", cap_data.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (cap_data[i] !== word(exp4[i])) begin errors++; $display("FAIL wrap_data%0d: got %h want %h", i, cap_data[i], word(exp4[i])); end
        end
        issue_ar(32'h28, 8'd2, 3'd2, 2'b10, 4'd7);
        capture(-1, 0);
        checks++; if (cap_data.size() !== 3) begin errors++; $display("FAIL wrap3_count: got %0d want 3", cap_data.size()); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (cap_data[i] !== word(exp3[i])) begin errors++; $display("FAIL wrap3_data%0d: got %h want %h", i, cap_data[i], word(exp3[i])); end
        end
    endtask

    task automatic test_fixed_clamp();
        issue_ar(32'h30, 8'd2, 3'd2, 2'b00, 4'd1);
        capture(-1, 0);
        for (int i = 0; i < 3; i++) begin
            checks++; if (cap_data[i] !== word(12)) begin errors++; $display("FAIL fixed_data%0d: got %h want %h", i, cap_data[i], word(12)); end
        end
        // arsize 3 exceeds the 4-byte bus and must step by 4.
        issue_ar(32'h0, 8'd1, 3'd3, 2'b01, 4'd2);
        capture(-1, 0);
        checks++; if (cap_data[1] !== word(1)) begin errors++; $display("FAIL clamp_data1: got %h want %h", cap_data[1], word(1)); end
    endtask

    task automatic test_backpressure();
        issue_ar(32'h40, 8'd3, 3'd2, 2'b01, 4'd9);
        capture(2, 3);
        checks++; if (hold_viol !== 0) begin errors++; $display("FAIL bp_hold: got %0d changes want 0", hold_viol); end
        checks++; if (cap_data.size() !== 4) begin errors++; $display("FAIL bp_count: got %0d want 4", cap_data.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (cap_data[i] !== word(16 + i)) begin errors++; $display("FAIL bp_data%0d: got %h want %h", i, cap_data[i], word(16 + i)); end
        end
        checks++; if (cap_cyc[3] - cap_cyc[0] !== 6) begin errors++; $display("FAIL bp_spacing: got %0d want 6", cap_cyc[3] - cap_cyc[0]); end
    endtask

    task automatic test_range();
        issue_ar(32'hFFC, 8'd1, 3'd2, 2'b01, 4'd4);
        capture(-1, 0);
        checks++; if (cap_resp[0] !== 2'b00 || cap_data[0] !== word(1023)) begin errors++; $display("FAIL range_beat0: got %b/%h want 00/%h", cap_resp[0], cap_data[0], word(1023)); end
        checks++; if (cap_resp[1] !== 2'b11 || cap_data[1] !== 32'h0) begin errors++; $display("FAIL range_beat1: got %b/%h want 11/0", cap_resp[1], cap_data[1]); end
        checks++; if (cap_last[0] !== 1'b0 || cap_last[1] !== 1'b1) begin errors++; $display("FAIL range_last: got %b%b want 01", cap_last[0], cap_last[1]); end
    endtask

    task automatic test_len255();
        int nlast;
        issue_ar(32'h0, 8'd255, 3'd2, 2'b01, 4'd6);
        capture(-1, 0);
        nlast = 0;
        foreach (cap_last[i]) if (cap_last[i] === 1'b1) nlast++;
        checks++; if (cap_data.size() !== 256) begin errors++; $display("FAIL len255_count: got %0d want 256", cap_data.size()); end
        checks++; if (nlast !== 1 || cap_last[255] !== 1'b1) begin errors++; $display("FAIL len255_last: got %0d lasts want 1 at beat 255", nlast); end
        checks++; if (cap_data[255] !== word(255)) begin errors++; $display("FAIL len255_data: got %h want %h", cap_data[255], word(255)); end
        checks++; if (arready !== 1'b1 || rvalid !== 1'b0) begin errors++; $display("FAIL len255_after: arready=%b rvalid=%b want 1 0", arready, rvalid); end
    endtask

    task automatic test_reset_midburst();
        int n;
        issue_ar(32'h20, 8'd3, 3'd2, 2'b01, 4'd2);
        rready = 1'b1;
        n = 0;
        while (rvalid !== 1'b1 && n < 20) begin step(); n++; end
        step();
        checks++; if (rvalid !== 1'b1 || rdata !== word(9)) begin errors++; $display("FAIL rst_beat1: got %b/%h want 1/%h", rvalid, rdata, word(9)); end
        i_rst_n = 1'b0;
        #1;
        checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid_async: got %b want 0", rvalid); end
        step();
        i_rst_n = 1'b1;
        step();
        checks++; if (arready !== 1'b1) begin errors++; $display("FAIL rst_arready_after: got %b want 1", arready); end
        issue_ar(32'h10, 8'd0, 3'd2, 2'b01, 4'd5);
        capture(-1, 0);
        checks++; if (cap_data[0] !== 32'hDEADBEEF || cap_id[0] !== 4'd5) begin errors++; $display("FAIL rst_reissue: got %h/%0d want DEADBEEF/5", cap_data[0], cap_id[0]); end
    endtask

    initial begin
        arvalid = 1'b0; araddr = '0; arid = '0; arlen = '0; arsize = '0; arburst = '0; rready = 1'b0;
        for (int i = 0; i < 1024; i++) dut.rom_mem[i] = word(i);
        test_reset();
        test_single();
        test_incr();
        test_wrap();
        test_fixed_clamp();
        test_backpressure();
        test_range();
        test_len255();
        test_reset_midburst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
